// File: rtl/key_sequencer.sv
// key_sequencer: run-length key event recorder with one-shot or looping cycle-exact playback
module key_sequencer #(
  parameter int KEY_W   = 4,
  parameter int DEPTH   = 32,
  parameter int DUR_W   = 26,
  parameter int MAX_DUR = 49_999_999
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rec_start,
  input  logic                         play_start,
  input  logic                         stop,
  input  logic                         loop_en,
  input  logic [KEY_W-1:0]             keys,
  output logic [KEY_W-1:0]             playback_keys,
  output logic [1:0]                   mode,
  output logic [$clog2(DEPTH+1)-1:0]   length,
  output logic                         full
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'b00, REC = 2'b01, PLAY = 2'b10;

  logic [1:0]       r_state, w_next;
  logic [KEY_W-1:0] r_pk, r_held;
  logic [LW-1:0]    r_len;
  logic             r_full;
  logic [DUR_W-1:0] r_dur, r_remain;
  logic [AW-1:0]    r_rd, w_rd_nxt, w_ld;
  logic [KEY_W-1:0] r_mem_k [DEPTH];
  logic [DUR_W-1:0] r_mem_d [DEPTH];
  logic             w_dur_max, w_wr, w_wr_last, w_rd_last;

  assign w_dur_max = r_dur == DUR_W'(MAX_DUR);
  assign w_wr      = r_state == REC && (stop || keys != r_held || w_dur_max);
  assign w_wr_last = w_wr && r_len == LW'(DEPTH - 1);
  assign w_rd_last = LW'(r_rd) == r_len - LW'(1);
  assign w_rd_nxt  = r_rd + AW'(1);
  // the write pointer is the entry count itself; reads wrap to entry 0 at the end and when starting from IDLE
  assign w_ld      = (r_state == PLAY && !w_rd_last) ? w_rd_nxt : '0;

  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;

  // next-state logic; only the three legal encodings are ever produced
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = rec_start ? REC : (play_start && r_len != '0) ? PLAY : IDLE;
      REC:     w_next = (stop || w_wr_last) ? IDLE : REC;
      PLAY:    w_next = (stop || (r_remain == '0 && w_rd_last && !loop_en)) ? IDLE : PLAY;
      default: w_next = IDLE;
    endcase
  end

  // outputs decoded from the state register and datapath registers
  always_comb begin
    mode          = r_state;
    playback_keys = r_pk;
    length        = r_len;
    full          = r_full;
  end

  // entry storage is deliberately unreset; slots at or above length are don't-care
  always_ff @(posedge clock)
    if (w_wr) begin
      r_mem_k[r_len[AW-1:0]] <= r_held;
      r_mem_d[r_len[AW-1:0]] <= r_dur;
    end

  // recording counters and playback datapath
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_pk     <= '0;
      r_held   <= '0;
      r_len    <= '0;
      r_full   <= 1'b0;
      r_dur    <= '0;
      r_remain <= '0;
      r_rd     <= '0;
    end else
      case (r_state)
        IDLE:
          if (rec_start) begin
            r_len  <= '0;
            r_full <= 1'b0;
            r_held <= keys;
            r_dur  <= '0;
          end else if (play_start && r_len != '0) begin
            r_pk     <= r_mem_k[w_ld];
            r_remain <= r_mem_d[w_ld];
            r_rd     <= '0;
          end
        REC: begin
          if (w_wr) begin
            r_len  <= r_len + LW'(1);
            r_full <= w_wr_last;
          end
          if (!stop) begin
            r_held <= keys;
            r_dur  <= (keys != r_held || w_dur_max) ? '0 : r_dur + DUR_W'(1);
          end
        end
        PLAY:
          if (stop) r_pk <= '0;
          else if (r_remain != '0) r_remain <= r_remain - DUR_W'(1);
          else if (w_rd_last && !loop_en) r_pk <= '0;
          else begin
            r_rd     <= w_ld;
            r_pk     <= r_mem_k[w_ld];
            r_remain <= r_mem_d[w_ld];
          end
        default: r_pk <= '0;
      endcase
endmodule
